// File: rtl/sort_pkg.sv
// Shared definitions for the sort datapath and its checker.
package sort_pkg;
  localparam int SORT_N = 8;
  localparam int SORT_W = 4;

  typedef logic [SORT_W-1:0] elem_t;

  typedef enum logic [1:0] {IDLE, SCAN, VERIFY, DONE} state_t;

  // Element 0 sits in the most significant slot of the packed vector.
  function automatic elem_t unpack_elem(input logic [SORT_N*SORT_W-1:0] vec,
                                        input int unsigned i);
    return elem_t'(vec >> ((SORT_N - 1 - i) * SORT_W));
  endfunction
endpackage

// File: rtl/sort_hist.sv
// Signed histogram: one inc and one dec per cycle, plus a read-and-clear port.
module sort_hist
  import sort_pkg::*;
#(
  parameter int W  = SORT_W,
  parameter int HW = $clog2(SORT_N) + 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_upd_en,
  input  logic [W-1:0]         i_inc_idx,
  input  logic [W-1:0]         i_dec_idx,
  input  logic                 i_rc_en,
  input  logic [W-1:0]         i_rc_idx,
  output logic signed [HW-1:0] o_rc_val
);
  localparam int NB = 1 << W;

  logic [NB-1:0][HW-1:0] r_hist;
  logic [NB-1:0][HW-1:0] w_delta;
  logic [NB-1:0]         w_clr;

  assign o_rc_val = $signed(r_hist[i_rc_idx]);

  // Per-bin net change; inc and dec on the same bin cancel out.
  always_comb begin
    w_delta = '0;
    w_clr   = '0;
    for (int k = 0; k < NB; k++) begin
      if (i_upd_en && i_inc_idx == W'(k) && i_dec_idx != W'(k)) w_delta[k] = HW'(1);
      if (i_upd_en && i_dec_idx == W'(k) && i_inc_idx != W'(k)) w_delta[k] = '1;
      w_clr[k] = i_rc_en && (i_rc_idx == W'(k));
    end
  end

  // Counter array; clear on read wins over update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (w_clr[k]) r_hist[k] <= '0;
        else          r_hist[k] <= r_hist[k] + w_delta[k];
      end
    end
  end
endmodule

// File: rtl/sort_checker.sv
// Checks that B is an ordered permutation of A: order scan, then histogram sweep.
module sort_checker
  import sort_pkg::*;
#(
  parameter int N       = SORT_N,
  parameter int W       = SORT_W,
  parameter bit DESCEND = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N*W-1:0] i_a,
  input  logic [N*W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_pass,
  output logic         o_order_err,
  output logic         o_perm_err
);
  localparam int NB   = 1 << W;
  localparam int MAXC = (N > NB) ? N : NB;
  localparam int CW   = $clog2(MAXC);
  localparam int HW   = $clog2(N) + 2;
  localparam logic [CW-1:0] LAST_SCAN = CW'(N - 1);
  localparam logic [CW-1:0] LAST_BIN  = CW'(NB - 1);

  state_t r_state, w_next;
  logic [N*W-1:0] r_a, r_b;
  logic [CW-1:0]  r_idx;
  logic r_busy, r_done, r_pass, r_order_err, r_perm_err;
  logic w_accept, w_scan, w_verify, w_last_scan, w_last_bin, w_bad;
  elem_t w_a_cur, w_b_cur, w_b_prev;
  logic signed [HW-1:0] w_bin;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start)    w_next = SCAN;
      SCAN:    if (w_last_scan) w_next = VERIFY;
      VERIFY:  if (w_last_bin)  w_next = DONE;
      default:                  w_next = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    w_accept    = (r_state == IDLE) && i_start;
    w_scan      = (r_state == SCAN);
    w_verify    = (r_state == VERIFY);
    w_last_scan = w_scan && (r_idx == LAST_SCAN);
    w_last_bin  = w_verify && (r_idx == LAST_BIN);
  end

  assign w_a_cur  = unpack_elem(r_a, 32'(r_idx));
  assign w_b_cur  = unpack_elem(r_b, 32'(r_idx));
  assign w_b_prev = unpack_elem(r_b, 32'(r_idx) - 32'd1);
  assign w_bad    = DESCEND ? (w_b_cur > w_b_prev) : (w_b_cur < w_b_prev);

  sort_hist #(.W(W), .HW(HW)) u_hist (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_upd_en  (w_scan),
    .i_inc_idx (w_a_cur),
    .i_dec_idx (w_b_cur),
    .i_rc_en   (w_verify),
    .i_rc_idx  (W'(r_idx)),
    .o_rc_val  (w_bin)
  );

  // Operand capture, index counter, sticky error flags and registered status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '0; r_b <= '0; r_idx <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_pass <= 1'b0;
      r_order_err <= 1'b0; r_perm_err <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      r_busy <= (w_next != IDLE);
      if (w_accept) begin
        r_a <= i_a; r_b <= i_b; r_idx <= '0;
        r_pass <= 1'b0; r_order_err <= 1'b0; r_perm_err <= 1'b0;
      end else if (w_scan) begin
        r_idx <= w_last_scan ? '0 : r_idx + CW'(1);
        if (r_idx != '0 && w_bad) r_order_err <= 1'b1;
      end else if (w_verify) begin
        r_idx <= w_last_bin ? '0 : r_idx + CW'(1);
        if (w_bin != '0) r_perm_err <= 1'b1;
      end else if (r_state == DONE) begin
        r_pass <= !r_order_err && !r_perm_err;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_order_err = r_order_err;
  assign o_perm_err  = r_perm_err;
endmodule
